// File: rtl/wb_lfsr_initiator_pkg.sv
// rtl/wb_lfsr_initiator_pkg.sv - shared types and constants for the LFSR responder initiator
// Contents: FSM state enum, default bus widths, responder register map.
package wb_lfsr_initiator_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  // Register map of the LFSR responder; shared with the responder RTL.
  localparam logic [2:0] REG_SEED = 3'd0;
  localparam logic [2:0] REG_TAPS = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_BIT  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/wb_lfsr_initiator_if.sv
// rtl/wb_lfsr_initiator_if.sv - command/response and Wishbone pins of the initiator
// master : initiator view (cmd/rsp handshake in, Wishbone pipelined bus out)
// slave  : sequencer + responder view (drives commands, rsp_ready, stall/ack/data)
interface wb_lfsr_initiator_if
  import wb_lfsr_initiator_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_we;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_data;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_err;
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [DATA_W-1:0] o_wb_data;
  logic              i_wb_stall;
  logic              i_wb_data;
  logic              i_wb_ack;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready,
    input  i_wb_stall, i_wb_data, i_wb_ack,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready,
    output i_wb_stall, i_wb_data, i_wb_ack,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );

endinterface

// File: rtl/wb_lfsr_initiator_ack_timer.sv
// rtl/wb_lfsr_initiator_ack_timer.sv - saturating no-progress timer for the bus cycle
// i_clk, i_reset : clock, synchronous active-high reset
// i_enable       : count this cycle (transaction in flight)
// i_clear        : progress seen this cycle, restart from zero
// o_expire       : this cycle is the TIMEOUT_CYCLES-th consecutive idle cycle
module wb_ack_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && count_q != T_MAX) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the idle cycles already completed, so expiry fires during
  // the cycle that brings the count to TIMEOUT_CYCLES and the abort lands on
  // that same edge.
  assign o_expire = i_enable && !i_clear && (count_q >= T_LAST);

endmodule

// File: rtl/wb_lfsr_initiator.sv
// rtl/wb_lfsr_initiator.sv - Wishbone pipelined initiator for the 1-bit LFSR responder
// i_clk, i_reset : clock, synchronous active-high reset
// bus (master)   : cmd_valid/ready + we/addr/data in; rsp_valid/ready + data/err out;
//                  wb cyc/stb/we/addr/data out; wb stall/data/ack in
// Writes issue one beat; reads issue READ_BITS beats and pack the bits LSB-first.
module wb_lfsr_initiator
  import wb_lfsr_initiator_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int READ_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wb_lfsr_initiator_if.master  bus
);

  localparam int CNT_W = $clog2(READ_BITS + 1);

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, shreg_q, shreg_d;
  logic [CNT_W-1:0]  beats_q, beats_d, issued_q, issued_d, acked_q, acked_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              beat_issue, ack_take, timer_en, timer_clr, timer_expire;
  logic [CNT_W-1:0]  issued_nx, acked_nx;
  logic [DATA_W-1:0] shreg_nx;

  wb_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (timer_en),
    .i_clear  (timer_clr),
    .o_expire (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    beats_d     = beats_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    timer_en    = 1'b0;
    timer_clr   = 1'b0;

    // stb is only ever high in REQ, so these need no state qualifier.
    beat_issue = stb_q && !bus.i_wb_stall;
    issued_nx  = issued_q + CNT_W'(beat_issue);
    // Gating with issued_nx keeps acked <= issued even for stray acks, while
    // still accepting the same-cycle ack of a zero-wait responder.
    ack_take   = cyc_q && bus.i_wb_ack && (acked_q < issued_nx);
    acked_nx   = acked_q + CNT_W'(ack_take);
    shreg_nx   = shreg_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (ack_take && !we_q && acked_q == CNT_W'(i)) begin
        shreg_nx[i] = bus.i_wb_data;
      end
    end
    issued_d = issued_nx;
    acked_d  = acked_nx;
    shreg_d  = shreg_nx;

    unique case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (bus.i_cmd_valid) begin
          we_d     = bus.i_cmd_we;
          addr_d   = bus.i_cmd_addr;
          data_d   = bus.i_cmd_data;
          beats_d  = bus.i_cmd_we ? CNT_W'(1) : CNT_W'(READ_BITS);
          issued_d = '0;
          acked_d  = '0;
          shreg_d  = '0;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        timer_en  = 1'b1;
        timer_clr = beat_issue || ack_take;
        if (state_q == ST_REQ && issued_nx == beats_q) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
        if (issued_nx == beats_q && acked_nx == beats_q) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = we_q ? '0 : shreg_nx;
          state_d     = ST_RESP;
        end else if (timer_expire) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = shreg_nx;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      beats_q     <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      shreg_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      beats_q     <= beats_d;
      issued_q    <= issued_d;
      acked_q     <= acked_d;
      shreg_q     <= shreg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.o_cmd_ready = (state_q == ST_IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_wb_cyc    = cyc_q;
  assign bus.o_wb_stb    = stb_q;
  assign bus.o_wb_we     = we_q;
  assign bus.o_wb_addr   = addr_q;
  assign bus.o_wb_data   = data_q;

endmodule

// File: tb/tb_wb_lfsr_initiator.sv
// tb/tb_wb_lfsr_initiator.sv - directed self-checking bench for wb_lfsr_initiator
module tb_wb_lfsr_initiator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_lfsr_initiator_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  wb_lfsr_initiator #(
    .ADDR_W(3), .DATA_W(8), .READ_BITS(8), .TIMEOUT_CYCLES(255)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Responder model: zero-wait ack on every accepted beat, bit pattern by beat index.
  logic [7:0] rd_bits = 8'h00;
  int         stall_from = 100;
  logic       stall3_en = 1'b0;
  int         beat_cnt, stall_done;

  always_comb begin
    bus.i_wb_stall = (beat_cnt >= stall_from) || (stall3_en && beat_cnt == 2 && stall_done < 3);
    bus.i_wb_ack   = bus.o_wb_cyc && bus.o_wb_stb && !bus.i_wb_stall;
    bus.i_wb_data  = rd_bits[beat_cnt[2:0]];
  end

  // Bus monitor.
  int         cyc_cnt, stb_cnt, issue_cnt, ack_cnt, addr_bad, edge_num, last_ack_at;
  logic [2:0] mon_addr, exp_addr;
  logic [7:0] mon_data;
  logic       exp_we;

  always @(posedge clk) begin
    edge_num <= edge_num + 1;
    if (bus.i_cmd_valid && bus.o_cmd_ready) begin
      cyc_cnt <= 0; stb_cnt <= 0; issue_cnt <= 0; ack_cnt <= 0; addr_bad <= 0;
      beat_cnt <= 0; stall_done <= 0;
    end else begin
      if (bus.o_wb_cyc) cyc_cnt <= cyc_cnt + 1;
      if (bus.o_wb_stb) stb_cnt <= stb_cnt + 1;
      if (bus.o_wb_stb && !bus.i_wb_stall) begin
        issue_cnt <= issue_cnt + 1;
        beat_cnt  <= beat_cnt + 1;
        mon_addr  <= bus.o_wb_addr;
        mon_data  <= bus.o_wb_data;
      end
      if (bus.o_wb_stb && bus.i_wb_stall && stall3_en && beat_cnt == 2) stall_done <= stall_done + 1;
      if (bus.o_wb_cyc && bus.i_wb_ack) begin
        ack_cnt     <= ack_cnt + 1;
        last_ack_at <= edge_num + 1;
      end
      if (bus.o_wb_stb && (bus.o_wb_addr != exp_addr || bus.o_wb_we != exp_we)) addr_bad <= addr_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    check("cmd_ready_idle", bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = data;
    exp_addr        = addr;
    exp_we          = we;
    @(posedge clk);
    #1 bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_rsp_valid && n < max);
    check("rsp_valid_arrives", bus.o_rsp_valid, 1);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
    check("rsp_valid_cleared", bus.o_rsp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = 3'd0;
    bus.i_cmd_data  = 8'h00;
    bus.i_rsp_ready = 1'b0;
    exp_addr = 3'd0;
    exp_we   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", bus.o_wb_cyc, 0);
    check("rst_stb", bus.o_wb_stb, 0);
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    check("rst_rsp_valid", bus.o_rsp_valid, 0);
    check("rst_rsp_err", bus.o_rsp_err, 0);
    check("rst_rsp_data", bus.o_rsp_data, 8'h00);
    rst = 1'b0;

    // Write, zero-wait.
    send(1'b1, 3'd3, 8'hA5);
    wait_rsp(20);
    check("wr_stb_cycles", stb_cnt, 1);
    check("wr_cyc_cycles", cyc_cnt, 1);
    check("wr_addr", mon_addr, 3'd3);
    check("wr_data", mon_data, 8'hA5);
    check("wr_rsp_data", bus.o_rsp_data, 8'h00);
    check("wr_rsp_err", bus.o_rsp_err, 0);
    check("wr_cyc_low", bus.o_wb_cyc, 0);
    handshake();

    // Read, zero-wait: bits 1,0,1,1,0,0,1,0 -> 0x4D; then 5 cycles of backpressure.
    rd_bits = 8'h4D;
    send(1'b0, 3'd5, 8'h00);
    wait_rsp(40);
    check("rd_stb_cycles", stb_cnt, 8);
    check("rd_cyc_cycles", cyc_cnt, 8);
    check("rd_acks", ack_cnt, 8);
    check("rd_addr_stable", addr_bad, 0);
    check("rd_rsp_data", bus.o_rsp_data, 8'h4D);
    check("rd_rsp_err", bus.o_rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", bus.o_rsp_valid, 1);
      check("bp_rsp_data", bus.o_rsp_data, 8'h4D);
      check("bp_cmd_ready", bus.o_cmd_ready, 0);
    end
    handshake();

    // Read with a 3-cycle stall on beat 2: bits 0,1,1,0,1,1,0,1 -> 0xB6.
    rd_bits   = 8'hB6;
    stall3_en = 1'b1;
    send(1'b0, 3'd2, 8'h00);
    wait_rsp(40);
    check("st_stb_cycles", stb_cnt, 11);
    check("st_issued", issue_cnt, 8);
    check("st_acks", ack_cnt, 8);
    check("st_addr_stable", addr_bad, 0);
    check("st_rsp_data", bus.o_rsp_data, 8'hB6);
    check("st_rsp_err", bus.o_rsp_err, 0);
    handshake();
    stall3_en = 1'b0;

    // Timeout: two beats (bits 0,1) then permanent stall -> 0x02 with err.
    rd_bits    = 8'hFE;
    stall_from = 2;
    send(1'b0, 3'd6, 8'h00);
    wait_rsp(400);
    check("to_rsp_err", bus.o_rsp_err, 1);
    check("to_rsp_data", bus.o_rsp_data, 8'h02);
    check("to_cyc", bus.o_wb_cyc, 0);
    check("to_stb", bus.o_wb_stb, 0);
    check("to_issued", issue_cnt, 2);
    check("to_latency", edge_num - last_ack_at, 255);
    handshake();

    // Reset in the middle of a stalled read.
    stall_from = 3;
    send(1'b0, 3'd1, 8'h00);
    repeat (6) @(negedge clk);
    check("mid_cyc_high", bus.o_wb_cyc, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_cyc", bus.o_wb_cyc, 0);
    check("mr_stb", bus.o_wb_stb, 0);
    check("mr_we", bus.o_wb_we, 0);
    check("mr_addr", bus.o_wb_addr, 3'd0);
    check("mr_data", bus.o_wb_data, 8'h00);
    check("mr_cmd_ready", bus.o_cmd_ready, 1);
    check("mr_rsp_valid", bus.o_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    stall_from = 100;
    repeat (3) @(negedge clk);
    check("mr_no_rsp", bus.o_rsp_valid, 0);

    // Recovery write after reset.
    send(1'b1, 3'd7, 8'h3C);
    wait_rsp(20);
    check("rc_data", mon_data, 8'h3C);
    check("rc_addr", mon_addr, 3'd7);
    check("rc_rsp_err", bus.o_rsp_err, 0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
